// File: rtl/tx_fire_sequencer.sv
// Fire sequencer for a bank of transducer channels: loads per-channel phase/charge
// words, broadcasts the shared command and fire-window counter, and handles errors.
module tx_fire_sequencer #(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 70000,
    localparam int AW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tbl_wr,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [31:0]         tbl_data,
    input  logic                fire_req,
    input  logic                abort,
    input  logic [7:0]          num_pulses,
    input  logic [15:0]         interval,
    input  logic [NCH-1:0]      tx_active,
    input  logic [NCH-1:0]      tx_error,
    output logic [1:0]          cmd,
    output logic [31:0]         cntr,
    output logic [32*NCH-1:0]   phase_charge,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                timeout_err,
    output logic [7:0]          pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRE, S_GAP, S_CLEAR, S_DONE
    } state_t;

    localparam logic [1:0] CMD_WAIT  = 2'b00;
    localparam logic [1:0] CMD_FIRE  = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_cntr;
    logic [15:0]         r_gap;
    logic [7:0]          r_num;
    logic [15:0]         r_interval;
    logic [7:0]          r_pulse_cnt;
    logic                r_err;
    logic                r_timeout_err;
    logic                r_zero_done;
    logic [32*NCH-1:0]   r_phase_charge;
    logic [31:0]         r_tbl [NCH];

    logic w_start;
    logic w_zero_req;
    logic w_any_err;
    logic w_fire_end;
    logic w_timeout;
    logic w_gap_end;
    logic w_last;

    assign w_start    = (r_state == S_IDLE) && fire_req && (num_pulses != 8'd0);
    assign w_zero_req = (r_state == S_IDLE) && fire_req && (num_pulses == 8'd0);
    assign w_any_err  = |tx_error;
    assign w_fire_end = (r_cntr >= 32'd2) && (tx_active == '0);
    assign w_timeout  = (r_cntr == 32'(TIMEOUT - 1));
    // interval=0 still yields one GAP cycle, so the end test is gap+1 >= interval.
    assign w_gap_end  = ({1'b0, r_gap} + 17'd1) >= {1'b0, r_interval};
    assign w_last     = (r_pulse_cnt == r_num);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_LOAD;
            S_LOAD:  w_next = abort ? S_CLEAR : S_FIRE;
            S_FIRE: begin
                if (abort || w_any_err) w_next = S_CLEAR;
                else if (w_fire_end)    w_next = S_GAP;
                else if (w_timeout)     w_next = S_CLEAR;
            end
            S_GAP: begin
                if (abort || w_any_err) w_next = S_CLEAR;
                else if (w_gap_end)     w_next = w_last ? S_DONE : S_LOAD;
            end
            S_CLEAR: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd = CMD_WAIT;
        case (r_state)
            S_FIRE:  cmd = CMD_FIRE;
            S_CLEAR: cmd = CMD_RESET;
            default: cmd = CMD_WAIT;
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE) || r_zero_done;
    assign cntr         = r_cntr;
    assign phase_charge = r_phase_charge;
    assign err          = r_err;
    assign timeout_err  = r_timeout_err;
    assign pulse_cnt    = r_pulse_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cntr         <= '0;
            r_gap          <= '0;
            r_num          <= '0;
            r_interval     <= '0;
            r_pulse_cnt    <= '0;
            r_err          <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_zero_done    <= 1'b0;
            r_phase_charge <= '0;
        end else begin
            r_zero_done <= w_zero_req;
            r_cntr      <= (r_state == S_FIRE && w_next == S_FIRE) ? r_cntr + 32'd1 : '0;
            r_gap       <= (r_state == S_GAP && w_next == S_GAP) ? r_gap + 16'd1 : '0;

            if (w_start) begin
                r_num         <= num_pulses;
                r_interval    <= interval;
                r_pulse_cnt   <= '0;
                r_err         <= 1'b0;
                r_timeout_err <= 1'b0;
            end else begin
                if (r_state == S_FIRE && w_next == S_GAP)
                    r_pulse_cnt <= r_pulse_cnt + 8'd1;
                if ((r_state == S_FIRE || r_state == S_GAP) && w_any_err)
                    r_err <= 1'b1;
                // Channel errors outrank a timeout landing on the same cycle.
                if (r_state == S_FIRE && !abort && !w_any_err && !w_fire_end && w_timeout) begin
                    r_err         <= 1'b1;
                    r_timeout_err <= 1'b1;
                end
            end

            if (r_state == S_LOAD) begin
                for (int i = 0; i < NCH; i++)
                    r_phase_charge[32*i +: 32] <= r_tbl[i];
            end
        end
    end

    // NOTE: the table is plain storage with no reset; it survives reset_n so a
    // controller only reprograms it when the phases change.
    always_ff @(posedge clk) begin
        if (tbl_wr && r_state == S_IDLE && 32'(tbl_addr) < NCH)
            r_tbl[tbl_addr] <= tbl_data;
    end

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Self-checking bench: channel emulator plus a per-cycle expected trace computed
// from the sequencing rules (window length, gap length, pulse count).
module tb_tx_fire_sequencer;

    localparam int NCH     = 8;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tbl_wr;
    logic [2:0]        tbl_addr;
    logic [31:0]       tbl_data;
    logic              fire_req;
    logic              abort;
    logic [7:0]        num_pulses;
    logic [15:0]       interval;
    logic [NCH-1:0]    tx_active;
    logic [NCH-1:0]    tx_error;
    logic [1:0]        cmd;
    logic [31:0]       cntr;
    logic [32*NCH-1:0] phase_charge;
    logic              busy, done, err, timeout_err;
    logic [7:0]        pulse_cnt;

    logic [NCH-1:0]    force_act;
    logic [31:0]       m_tbl [NCH];
    int                n_vec = 0;
    int                n_bad = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] cntr;
        logic        done;
        logic        busy;
    } exp_t;

    tx_fire_sequencer #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .fire_req(fire_req), .abort(abort),
        .num_pulses(num_pulses), .interval(interval), .tx_active(tx_active),
        .tx_error(tx_error), .cmd(cmd), .cntr(cntr), .phase_charge(phase_charge),
        .busy(busy), .done(done), .err(err), .timeout_err(timeout_err),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    // Channel emulator: active from cntr=1 through cntr=phase_delay+charge_time.
    function automatic logic chan_active(input logic [31:0] w, input logic [1:0] c, input logic [31:0] n);
        int span;
        span = int'(w[15:0]) + int'(w[24:16]);
        return (c == 2'b10) && (n >= 1) && (int'(n) <= span);
    endfunction

    always_comb begin
        tx_active = force_act;
        for (int i = 0; i < NCH; i++)
            tx_active[i] = tx_active[i] | chan_active(phase_charge[32*i +: 32], cmd, cntr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input logic [31:0] d);
        tbl_wr = 1'b1; tbl_addr = 3'(a); tbl_data = d;
        tick();
        tbl_wr = 1'b0;
        m_tbl[a] = d;
    endtask

    task automatic rand_table();
        for (int i = 0; i < NCH; i++)
            write_tbl(i, {7'($urandom), 9'($urandom_range(0, 20)), 16'($urandom_range(0, 20))});
    endtask

    function automatic logic [32*NCH-1:0] model_pc();
        logic [32*NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[32*i +: 32] = m_tbl[i];
        return v;
    endfunction

    task automatic wait_fire_cntr(input int target, input string tag);
        int k = 0;
        while (!(cmd == 2'b10 && cntr == 32'(target)) && k < 400) begin
            tick();
            k++;
        end
        n_vec++;
        if (k >= 400) begin
            n_bad++;
            $display("FAIL %s: cntr=%0d never reached, required %0d", tag, cntr, target);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin tick(); k++; end
        n_vec++;
        if (busy) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%0b, required 0", busy);
        end
    endtask

    // Expected trace: per pulse LOAD, FIRE cntr 0..end, GAP max(interval,1); then DONE, IDLE.
    task automatic run_seq(input int np, input int iv, input bit misc, input string tag);
        exp_t q[$];
        int   span_max, c_end;
        logic [32*NCH-1:0] pc_exp;
        span_max = 0;
        for (int i = 0; i < NCH; i++)
            if (int'(m_tbl[i][15:0]) + int'(m_tbl[i][24:16]) > span_max)
                span_max = int'(m_tbl[i][15:0]) + int'(m_tbl[i][24:16]);
        c_end  = (span_max + 1 > 2) ? span_max + 1 : 2;
        pc_exp = model_pc();
        for (int p = 0; p < np; p++) begin
            q.push_back('{2'b00, 0, 1'b0, 1'b1});
            for (int c = 0; c <= c_end; c++) q.push_back('{2'b10, 32'(c), 1'b0, 1'b1});
            for (int g = 0; g < ((iv > 0) ? iv : 1); g++) q.push_back('{2'b00, 0, 1'b0, 1'b1});
        end
        q.push_back('{2'b00, 0, 1'b1, 1'b1});
        q.push_back('{2'b00, 0, 1'b0, 1'b0});

        num_pulses = 8'(np); interval = 16'(iv); fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            n_vec++;
            if ({cmd, cntr, done, busy} !== {q[k].cmd, q[k].cntr, q[k].done, q[k].busy}) begin
                n_bad++;
                $display("FAIL %s step %0d: cmd=%b cntr=%0d done=%b busy=%b, required cmd=%b cntr=%0d done=%b busy=%b",
                         tag, k, cmd, cntr, done, busy, q[k].cmd, q[k].cntr, q[k].done, q[k].busy);
            end
            if (q[k].cmd == 2'b10) begin
                n_vec++;
                if (phase_charge !== pc_exp) begin
                    n_bad++;
                    $display("FAIL %s phase_charge step %0d: got %h, required %h", tag, k, phase_charge, pc_exp);
                end
            end
            if (misc && k == 2) begin
                tbl_wr = 1'b1; tbl_addr = 3'd0; tbl_data = ~m_tbl[0];
                fire_req = 1'b1; num_pulses = 8'(np + 1);
            end else if (misc && k == 3) begin
                tbl_wr = 1'b0; fire_req = 1'b0; num_pulses = 8'(np);
            end
            if (k < q.size() - 1) tick();
        end
        n_vec++;
        if ({pulse_cnt, err, timeout_err} !== {8'(np), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s end: pulse_cnt=%0d err=%b timeout_err=%b, required %0d 0 0",
                     tag, pulse_cnt, err, timeout_err, np);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({cmd, cntr, phase_charge, busy, done, err, timeout_err, pulse_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset: cmd=%b cntr=%0d busy=%b done=%b err=%b tmo=%b pcnt=%0d, required all 0",
                     cmd, cntr, busy, done, err, timeout_err, pulse_cnt);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < NCH; i++) write_tbl(i, (i == 0) ? 32'h0005_0003 : 32'h0);
        run_seq(1, 4, 1'b0, "single");
    endtask

    task automatic test_multi();
        rand_table();
        run_seq(3, 10, 1'b0, "multi");
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            rand_table();
            run_seq($urandom_range(1, 4), $urandom_range(0, 6), 1'b0, "random");
        end
    endtask

    task automatic test_write_block();
        rand_table();
        run_seq(2, 2, 1'b1, "busy_ignore");
        run_seq(1, 0, 1'b0, "write_block");
    endtask

    task automatic test_error();
        rand_table();
        write_tbl(0, 32'h000A_001E);
        num_pulses = 8'd2; interval = 16'd3; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        wait_fire_cntr(20, "error_wait");
        tx_error[2] = 1'b1;
        tick();
        tx_error = '0;
        n_vec++;
        if ({cmd, err, busy} !== {2'b11, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL error_clear: cmd=%b err=%b busy=%b, required 11 1 1", cmd, err, busy);
        end
        tick();
        n_vec++;
        if ({cmd, done} !== {2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL error_done: cmd=%b done=%b, required 00 1", cmd, done);
        end
        tick();
        n_vec++;
        if ({busy, done, err, pulse_cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL error_sticky: busy=%b done=%b err=%b pcnt=%0d, required 0 0 1 0", busy, done, err, pulse_cnt);
        end
        num_pulses = 8'd1; interval = 16'd0; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL error_cleared: err=%b, required 0", err);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        rand_table();
        force_act = 8'b0000_0010;
        num_pulses = 8'd1; interval = 16'd0; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        wait_fire_cntr(TIMEOUT - 1, "timeout_wait");
        tick();
        force_act = '0;
        n_vec++;
        if ({cmd, timeout_err, err} !== {2'b11, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_clear: cmd=%b tmo=%b err=%b, required 11 1 1", cmd, timeout_err, err);
        end
        tick();
        n_vec++;
        if ({cmd, done} !== {2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_done: cmd=%b done=%b, required 00 1", cmd, done);
        end
        tick();
        n_vec++;
        if ({busy, timeout_err, pulse_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL timeout_idle: busy=%b tmo=%b pcnt=%0d, required 0 1 0", busy, timeout_err, pulse_cnt);
        end
    endtask

    task automatic test_abort_gap();
        rand_table();
        num_pulses = 8'd2; interval = 16'd10; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        wait_fire_cntr(1, "abort_wait");
        for (int k = 0; k < 400 && cmd == 2'b10; k++) tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if ({cmd, busy, err} !== {2'b11, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_clear: cmd=%b busy=%b err=%b, required 11 1 0", cmd, busy, err);
        end
        tick();
        n_vec++;
        if ({cmd, done, pulse_cnt} !== {2'b00, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL abort_done: cmd=%b done=%b pcnt=%0d, required 00 1 1", cmd, done, pulse_cnt);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if ({cmd, busy, done} !== {2'b00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_idle: cmd=%b busy=%b done=%b, required 00 0 0", cmd, busy, done);
        end
    endtask

    task automatic test_reset_mid_fire();
        rand_table();
        write_tbl(3, 32'h0004_0006);
        num_pulses = 8'd1; interval = 16'd0; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        wait_fire_cntr(3, "rst_wait");
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({cmd, cntr, busy, phase_charge, pulse_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_fire: cmd=%b cntr=%0d busy=%b pcnt=%0d, required all 0", cmd, cntr, busy, pulse_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_seq(1, 1, 1'b0, "after_reset");
    endtask

    task automatic test_zero_pulses();
        num_pulses = 8'd0; interval = 16'd5; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        n_vec++;
        if ({done, busy, cmd} !== {1'b1, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL zero_done: done=%b busy=%b cmd=%b, required 1 0 00", done, busy, cmd);
        end
        tick();
        n_vec++;
        if ({done, busy, cmd} !== {1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL zero_after: done=%b busy=%b cmd=%b, required 0 0 00", done, busy, cmd);
        end
    endtask

    initial begin
        reset_n = 1'b0; tbl_wr = 1'b0; tbl_addr = '0; tbl_data = '0;
        fire_req = 1'b0; abort = 1'b0; num_pulses = '0; interval = '0;
        tx_error = '0; force_act = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        test_single();
        test_multi();
        test_random();
        test_write_block();
        test_error();
        test_timeout();
        test_abort_gap();
        test_reset_mid_fire();
        test_zero_pulses();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_fire_sequencer.md
Name: tx_fire_sequencer

Overview:
Upstream controller for a bank of per-channel transducer output stages. It holds a per-channel phase/charge table and drives each channel's 32-bit phaseCharge word. It broadcasts the shared 2-bit command (00 wait, 10 fire, 11 reset_module) and the shared cycle counter. It sequences one or more fire events separated by a programmable interval, monitors each channel's isActive and errorFlag, and clears errors via a reset_module command.

Parameters:
NCH, 8, number of transducer channels
TIMEOUT, 70000, max fire-window length in cycles (must exceed 65535+511+2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tbl_wr  in  1  phase table write strobe
tbl_addr  in  $clog2(NCH)  table entry index
tbl_data  in  32  entry: [15:0] phase delay, [24:16] charge time, [31:25] ignored
fire_req  in  1  single-cycle start request
abort  in  1  terminate the sequence
num_pulses  in  8  fire events per request, sampled at start
interval  in  16  idle cycles between fire events, sampled at start
tx_active  in  NCH  isActive from each channel
tx_error  in  NCH  errorFlag from each channel
cmd  out  2  broadcast command
cntr  out  32  shared fire-window counter
phase_charge  out  32*NCH  channel i on bits [32i+31:32i]
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse at sequence end
err  out  1  sticky error, cleared on the next accepted fire_req
timeout_err  out  1  sticky, set when the fire window hits TIMEOUT
pulse_cnt  out  8  fire events completed in the current sequence

Behaviour:
- Reset (async): state IDLE; cmd=00, cntr=0, phase_charge=0, busy=0, done=0, err=0, timeout_err=0, pulse_cnt=0. The table is not reset.
- Table: NCH x 32 registers. Writes are accepted only in IDLE; writes while busy are dropped.
- IDLE: cmd=00, cntr=0.
  - fire_req=1 with num_pulses=0 -> done=1 for one cycle, no firing, stay IDLE.
  - fire_req=1 with num_pulses>0 -> latch num_pulses and interval; clear err, timeout_err and pulse_cnt; go to LOAD.
  - fire_req while busy is ignored.
- LOAD (1 cycle): cmd=00; phase_charge[i] <= table[i]; go to FIRE. phase_charge holds stable until the next LOAD.
- FIRE:
  - cmd=10. cntr=0 on the first FIRE cycle and increments by 1 each cycle.
  - Channels latch on the first FIRE cycle; tx_active is valid from cntr>=1.
  - End when cntr>=2 and tx_active==0: pulse_cnt++, then go to GAP.
  - If cntr reaches TIMEOUT-1 first: set timeout_err and err, go to CLEAR.
- GAP:
  - cmd=00 (channels reset their state), cntr=0, an internal gap counter counts interval cycles.
  - interval=0 gives a single GAP cycle.
  - At gap end: if pulse_cnt==num_pulses, go to DONE; otherwise go to LOAD.
- CLEAR (1 cycle): cmd=11, clears channel errorFlags; then go to DONE.
- DONE (1 cycle): cmd=00, done=1, go to IDLE.
- Error: any tx_error bit high in FIRE or GAP -> err=1, go to CLEAR the next cycle. Error takes priority over normal FIRE end and over timeout in the same cycle.
- Abort: abort=1 in any non-IDLE state except CLEAR/DONE -> go to CLEAR (cmd=11 drops all outputs), then DONE. abort in IDLE has no effect.
- Mid-operation async reset returns everything to reset values immediately; cmd=00 guarantees channel outputs fall.
- cntr is 32 bits and never wraps in practice (TIMEOUT bounds it).

Test Plan:
- Single fire: table[0]=0x0005_0003 (ct=5, pd=3), other channels 0; num_pulses=1, interval=4 -> cmd=10 from 2 cycles after fire_req. FIRE lasts until tx_active[0] drops at cntr=8 or 9. Then 4 GAP cycles, DONE, done pulse, pulse_cnt=1, err=0.
- Multi-pulse: num_pulses=3, interval=10 -> exactly 3 LOAD/FIRE windows, each with cntr restarting at 0. GAP lasts 10 cycles with cmd=00. pulse_cnt ends at 3; a single done pulse.
- Error injection: assert tx_error[2] at cntr=20 -> cmd=11 for exactly one cycle, then done. err=1 stays until the next fire_req, where it clears.
- Timeout: with TIMEOUT=100, hold tx_active[1]=1 -> at cntr=99 timeout_err=1 and err=1, cmd=11 for one cycle, then done.
- Abort and write blocking: abort during GAP -> CLEAR then DONE. tbl_wr while busy leaves the table unchanged (readback after the next LOAD). fire_req while busy is ignored.
- Reset and num_pulses=0: reset_n low mid-FIRE -> cmd=00 and cntr=0 immediately. fire_req with num_pulses=0 -> done the next cycle, cmd stays 00.
